// File: rtl/rv_fetch_stage_if.sv
// Instruction-memory request/grant/response channel between the fetch stage and memory.
interface rv_fetch_stage_if;
  localparam int unsigned XLEN = 32;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/rv_fetch_stage.sv
// IF stage and IF/ID register: owns pcF, keeps one fetch in flight, buffers responses
// that land during a stall and drops responses that belong to a redirected path.
module rv_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stallF,
  input  logic                    stallD,
  input  logic                    flushD,
  input  logic                    br_taken,
  input  logic [31:0]             br_target,
  rv_fetch_stage_if.master        imem,
  output logic [31:0]             instrD,
  output logic [31:0]             pcD,
  output logic [31:0]             pc_plus4D,
  output logic                    validD,
  output logic [31:0]             pcF
);
  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } out_state_e;

  out_state_e      state;
  out_state_e      state_n;
  logic [XLEN-1:0] out_pc;
  logic            buf_valid;
  logic [XLEN-1:0] buf_instr;
  logic [XLEN-1:0] buf_pc;
  logic            req;
  logic            fire;
  logic            accept;
  logic            id_load;

  // Issue/accept decode and outstanding-fetch tracker next state
  always_comb begin
    state_n = state;
    req     = !rst && !stallF && !buf_valid && !br_taken &&
              ((state == IDLE) || imem.imem_rvalid);
    fire    = req && imem.imem_gnt;
    accept  = imem.imem_rvalid && (state == WAIT) && !br_taken;
    id_load = !flushD && !stallD;
    if (imem.imem_rvalid && (state != IDLE)) state_n = IDLE;
    if (br_taken && (state == WAIT) && !imem.imem_rvalid) state_n = DROP;
    if (fire) state_n = WAIT;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pcF;

  // Fetch PC, in-flight PC and the one-entry stall buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      pcF       <= RESET_PC;
      out_pc    <= '0;
      buf_valid <= 1'b0;
      buf_instr <= '0;
      buf_pc    <= '0;
    end else begin
      if (br_taken)  pcF <= br_target;
      else if (fire) pcF <= pcF + XLEN'(4);
      if (fire) out_pc <= pcF;
      if (br_taken) begin
        buf_valid <= 1'b0;
      end else if (accept && !id_load) begin
        buf_valid <= 1'b1;
        buf_instr <= imem.imem_rdata;
        buf_pc    <= out_pc;
      end else if (buf_valid && id_load) begin
        buf_valid <= 1'b0;
      end
    end
  end

  // IF/ID register: flush > stall > buffer > fresh response > bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      instrD    <= NOP_INSN;
      pcD       <= '0;
      pc_plus4D <= XLEN'(4);
      validD    <= 1'b0;
    end else if (flushD) begin
      instrD <= NOP_INSN;
      validD <= 1'b0;
    end else if (!stallD) begin
      if (buf_valid) begin
        instrD    <= buf_instr;
        pcD       <= buf_pc;
        pc_plus4D <= buf_pc + XLEN'(4);
        validD    <= 1'b1;
      end else if (accept) begin
        instrD    <= imem.imem_rdata;
        pcD       <= out_pc;
        pc_plus4D <= out_pc + XLEN'(4);
        validD    <= 1'b1;
      end else begin
        instrD <= NOP_INSN;
        validD <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rv_fetch_stage.sv
// Self-checking bench for rv_fetch_stage: variable-latency memory returning rdata=addr,
// scoreboard of expected decode PCs popped whenever a new instruction reaches D.
module tb_rv_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallF, stallD, flushD, br_taken;
  logic [31:0] br_target;
  logic [31:0] instrD, pcD, pc_plus4D, pcF;
  logic        validD;

  rv_fetch_stage_if ifc ();

  rv_fetch_stage dut (
    .clk       (clk),
    .rst       (rst),
    .stallF    (stallF),
    .stallD    (stallD),
    .flushD    (flushD),
    .br_taken  (br_taken),
    .br_target (br_target),
    .imem      (ifc),
    .instrD    (instrD),
    .pcD       (pcD),
    .pc_plus4D (pc_plus4D),
    .validD    (validD),
    .pcF       (pcF)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] grants[$];
  int          lat = 1;
  logic        m_busy = 1'b0;
  logic [31:0] m_addr = '0;
  int          m_cnt = 0;

  // Memory model: response lat cycles after the grant, rdata = address
  always @(posedge clk) begin
    logic        fire_s, rv_s, rst_s;
    logic [31:0] a_s;
    fire_s = ifc.imem_req && ifc.imem_gnt;
    a_s    = ifc.imem_addr;
    rv_s   = ifc.imem_rvalid;
    rst_s  = rst;
    #1;
    if (rv_s || rst_s) m_busy = 1'b0;
    if (fire_s && !rst_s) begin
      m_busy = 1'b1;
      m_addr = a_s;
      m_cnt  = lat - 1;
      grants.push_back(a_s);
    end else if (m_busy && m_cnt > 0) begin
      m_cnt--;
    end
    ifc.imem_rvalid = m_busy && (m_cnt == 0);
    ifc.imem_rdata  = m_busy ? m_addr : 32'hDEAD_BEEF;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset(input int l);
    @(negedge clk);
    rst = 1'b1; stallF = 1'b0; stallD = 1'b0; flushD = 1'b0;
    br_taken = 1'b0; br_target = '0; ifc.imem_gnt = 1'b1; lat = l;
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    grants.delete();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (validD !== 1'b0) begin errors++; $display("FAIL reset_validD got %0b want 0", validD); end
    checks++; if (instrD !== NOP) begin errors++; $display("FAIL reset_instrD got %h want %h", instrD, NOP); end
    checks++; if (pcD !== 32'h0) begin errors++; $display("FAIL reset_pcD got %h want 0", pcD); end
    checks++; if (pc_plus4D !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4D got %h want 4", pc_plus4D); end
    checks++; if (pcF !== 32'h0) begin errors++; $display("FAIL reset_pcF got %h want 0", pcF); end
    checks++; if (ifc.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", ifc.imem_req); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] e;
    int first;
    first = -1;
    do_reset(1);
    for (int i = 0; i < 12; i++) exp_q.push_back(32'(i * 4));
    for (int c = 1; c <= 40 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (validD) begin
        if (first < 0) first = c;
        e = exp_q.pop_front();
        checks++;
        if (pcD !== e || instrD !== e || pc_plus4D !== e + 32'd4) begin
          errors++; $display("FAIL zw_data pcD=%h instrD=%h pc4=%h want pc=%h", pcD, instrD, pc_plus4D, e);
        end
      end else if (first >= 0) begin
        checks++; errors++; $display("FAIL zw_sustain cycle %0d validD=0 want 1", c);
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL zw_timeout left %0d want 0", exp_q.size()); end
    checks++; if (first != 2) begin errors++; $display("FAIL zw_first_valid cycle %0d want 2", first); end
  endtask

  task automatic test_grant_hold();
    logic [31:0] e;
    do_reset(1);
    ifc.imem_gnt = 1'b0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'h0 || pcF !== 32'h0) begin
        errors++; $display("FAIL gnt_hold req=%0b addr=%h pcF=%h want req=1 addr=0 pcF=0", ifc.imem_req, ifc.imem_addr, pcF);
      end
    end
    ifc.imem_gnt = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (validD) begin
        e = exp_q.pop_front();
        checks++;
        if (pcD !== e || instrD !== e) begin errors++; $display("FAIL gnt_data pcD=%h instrD=%h want %h", pcD, instrD, e); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL gnt_timeout left %0d want 0", exp_q.size()); end
  endtask

  task automatic test_slow_mem();
    logic [31:0] e;
    int last;
    last = -1;
    do_reset(3);
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
    for (int c = 1; c <= 40 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (m_busy && !ifc.imem_rvalid) begin
        checks++;
        if (ifc.imem_req !== 1'b0) begin errors++; $display("FAIL slow_req_in_wait got %0b want 0", ifc.imem_req); end
      end
      if (validD) begin
        e = exp_q.pop_front();
        checks++;
        if (pcD !== e || instrD !== e) begin errors++; $display("FAIL slow_data pcD=%h instrD=%h want %h", pcD, instrD, e); end
        if (last >= 0) begin
          checks++;
          if (c - last != 3) begin errors++; $display("FAIL slow_period got %0d want 3", c - last); end
        end
        last = c;
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL slow_timeout left %0d want 0", exp_q.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (grants.size() <= i || grants[i] !== 32'(i * 4)) begin
        errors++; $display("FAIL slow_grant_seq idx %0d got %h want %h", i, (grants.size() > i) ? grants[i] : 32'hX, 32'(i * 4));
      end
    end
  endtask

  task automatic test_stall_buffer();
    logic [31:0] e;
    logic prev_st;
    int left;
    logic done;
    prev_st = 1'b0; left = 0; done = 1'b0;
    do_reset(1);
    for (int i = 0; i < 7; i++) exp_q.push_back(32'(i * 4));
    for (int c = 1; c <= 60 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (prev_st) begin
        checks++;
        if (pcD !== 32'hC || validD !== 1'b1 || ifc.imem_req !== 1'b0) begin
          errors++; $display("FAIL stall_hold pcD=%h validD=%0b req=%0b want pcD=0c validD=1 req=0", pcD, validD, ifc.imem_req);
        end
      end else if (validD) begin
        e = exp_q.pop_front();
        checks++;
        if (pcD !== e || instrD !== e) begin errors++; $display("FAIL stall_data pcD=%h instrD=%h want %h", pcD, instrD, e); end
        if (e == 32'hC && !done) begin left = 4; done = 1'b1; end
      end
      stallF = (left > 0);
      stallD = (left > 0);
      prev_st = (left > 0);
      if (left > 0) left--;
    end
    stallF = 1'b0; stallD = 1'b0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_timeout left %0d want 0", exp_q.size()); end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (grants.size() <= i || grants[i] !== 32'(i * 4)) begin
        errors++; $display("FAIL stall_grant_seq idx %0d got %h want %h", i, (grants.size() > i) ? grants[i] : 32'hX, 32'(i * 4));
      end
    end
  endtask

  task automatic test_branch_drop();
    logic [31:0] e;
    int br_c;
    br_c = -1;
    do_reset(2);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    for (int c = 1; c <= 80 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (br_c >= 0 && c == br_c + 1) begin
        checks++;
        if (validD !== 1'b0 || instrD !== NOP) begin errors++; $display("FAIL brd_flush validD=%0b instrD=%h want 0/%h", validD, instrD, NOP); end
      end
      if (validD) begin
        e = exp_q.pop_front();
        checks++;
        if (pcD !== e || instrD !== e) begin errors++; $display("FAIL brd_data pcD=%h instrD=%h want %h", pcD, instrD, e); end
      end
      br_taken = 1'b0; flushD = 1'b0;
      if (br_c < 0 && m_busy && m_addr == 32'h20 && !ifc.imem_rvalid) begin
        br_taken = 1'b1; flushD = 1'b1; br_target = 32'h100; br_c = c;
      end
    end
    br_taken = 1'b0; flushD = 1'b0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL brd_timeout left %0d want 0", exp_q.size()); end
    checks++;
    if (grants.size() < 10 || grants[8] !== 32'h20 || grants[9] !== 32'h100) begin
      errors++; $display("FAIL brd_redirect_addr got %h want 100", (grants.size() > 9) ? grants[9] : 32'hX);
    end
  endtask

  task automatic test_branch_rvalid();
    logic [31:0] e;
    int br_c;
    br_c = -1;
    do_reset(1);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    for (int c = 1; c <= 40 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (br_c >= 0 && c == br_c + 1) begin
        checks++;
        if (validD !== 1'b0 || instrD !== NOP) begin errors++; $display("FAIL brr_flush validD=%0b instrD=%h want 0/%h", validD, instrD, NOP); end
      end
      if (validD) begin
        e = exp_q.pop_front();
        checks++;
        if (pcD !== e || instrD !== e) begin errors++; $display("FAIL brr_data pcD=%h instrD=%h want %h", pcD, instrD, e); end
        if (e == 32'h200) begin
          checks++;
          if (c - br_c != 3) begin errors++; $display("FAIL brr_penalty got %0d want 3", c - br_c); end
        end
      end
      br_taken = 1'b0; flushD = 1'b0;
      if (br_c < 0 && ifc.imem_rvalid && ifc.imem_rdata == 32'h8) begin
        br_taken = 1'b1; flushD = 1'b1; br_target = 32'h200; br_c = c;
      end
    end
    br_taken = 1'b0; flushD = 1'b0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL brr_timeout left %0d want 0", exp_q.size()); end
    checks++;
    if (grants.size() < 4 || grants[3] !== 32'h200) begin
      errors++; $display("FAIL brr_next_fetch got %h want 200", (grants.size() > 3) ? grants[3] : 32'hX);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    logic seen;
    seen = 1'b0;
    do_reset(1);
    br_taken = 1'b1; flushD = 1'b1; br_target = 32'hFFFF_FFF8;
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    for (int c = 1; c <= 30 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      br_taken = 1'b0; flushD = 1'b0;
      if (!seen && m_busy && m_addr == 32'hFFFF_FFFC) begin
        seen = 1'b1;
        checks++;
        if (pcF !== 32'h0) begin errors++; $display("FAIL wrap_pcF got %h want 0", pcF); end
      end
      if (validD) begin
        e = exp_q.pop_front();
        checks++;
        if (pcD !== e || instrD !== e || pc_plus4D !== e + 32'd4) begin
          errors++; $display("FAIL wrap_data pcD=%h instrD=%h pc4=%h want pc=%h", pcD, instrD, pc_plus4D, e);
        end
      end
    end
    checks++; if (exp_q.size() != 0 || !seen) begin errors++; $display("FAIL wrap_timeout left %0d seen %0b want 0/1", exp_q.size(), seen); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] e;
    logic hit;
    hit = 1'b0;
    do_reset(3);
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      if (grants.size() >= 3 && m_busy && !ifc.imem_rvalid) hit = 1'b1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL rmw_setup got 0 want 1"); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (validD !== 1'b0 || instrD !== NOP || pcD !== 32'h0 || pc_plus4D !== 32'h4 || pcF !== 32'h0 || ifc.imem_req !== 1'b0) begin
      errors++; $display("FAIL rmw_state validD=%0b instrD=%h pcD=%h pc4=%h pcF=%h req=%0b want 0/13/0/4/0/0",
                         validD, instrD, pcD, pc_plus4D, pcF, ifc.imem_req);
    end
    rst = 1'b0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (validD) begin
        e = exp_q.pop_front();
        checks++;
        if (pcD !== e || instrD !== e) begin errors++; $display("FAIL rmw_restart pcD=%h instrD=%h want %h", pcD, instrD, e); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rmw_timeout left %0d want 0", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b1; stallF = 1'b0; stallD = 1'b0; flushD = 1'b0;
    br_taken = 1'b0; br_target = '0;
    ifc.imem_gnt = 1'b1; ifc.imem_rvalid = 1'b0; ifc.imem_rdata = '0;
    test_reset();
    test_zero_wait();
    test_grant_hold();
    test_slow_mem();
    test_stall_buffer();
    test_branch_drop();
    test_branch_rvalid();
    test_wrap();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv_fetch_stage.md
Name: rv_fetch_stage

Overview:
- IF stage plus IF/ID pipeline register; the consumer of the hazard unit's stallF / stallD / flushD and branch-redirect outputs.
- Owns the fetch PC and drives a variable-latency instruction-memory request/grant/response interface, with at most one request outstanding.
- Holds responses that arrive during a stall in a 1-entry buffer, and discards in-flight fetches on redirect.
- Presents instrD / pcD / validD to decode.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSN, 32'h0000_0013, instruction injected into IF/ID on flush or bubble (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stallF  in  1  hold the PC; issue no new request.
- stallD  in  1  hold the IF/ID register.
- flushD  in  1  load a bubble into IF/ID.
- br_taken  in  1  redirect fetch; same-cycle as flushD.
- br_target  in  32  redirect address, word-aligned.
- imem_req  out  1  request valid.
- imem_addr  out  32  request address (= pcF).
- imem_gnt  in  1  request accepted this cycle when imem_req=1.
- imem_rvalid  in  1  response valid; exactly one per granted request, at least 1 cycle after the grant.
- imem_rdata  in  32  response instruction.
- instrD  out  32  IF/ID instruction.
- pcD  out  32  IF/ID PC.
- pc_plus4D  out  32  pcD+4.
- validD  out  1  IF/ID holds a real instruction.
- pcF  out  32  next fetch address (debug/trace).

Behaviour:
- Reset: synchronous, active-high, highest priority.
  - pcF=RESET_PC; instrD=NOP_INSN; pcD=0; pc_plus4D=4; validD=0.
  - Outstanding, drop and buf_valid flags cleared; imem_req=0 during the reset cycle.
  - A response arriving in the first cycles after reset is ignored only if drop was set before reset. Reset clears drop, so the memory must be quiesced with the core.
- Outstanding tracker: flags out_valid and out_drop, plus out_pc.
  - States: IDLE (out_valid=0), WAIT (out_valid=1, drop=0), DROP (out_valid=1, drop=1).
  - Outstanding is released in the cycle imem_rvalid=1.
- Request issue: imem_req=1 iff all of the following hold:
  - !rst and !stallF and !buf_valid;
  - (!out_valid or imem_rvalid), i.e. back-to-back issue in the response cycle;
  - !br_taken.
- On imem_req and imem_gnt: out_pc<=pcF; out_valid<=1; out_drop<=0; pcF<=pcF+4 (mod 2^32 wrap).
- No grant: imem_req stays asserted with imem_addr stable until grant, unless stallF or br_taken rises, in which case req may drop.
- Redirect (br_taken, priority over stallF):
  - pcF<=br_target.
  - If out_valid and no rvalid this cycle: out_drop<=1.
  - A response arriving in the br_taken cycle is discarded.
  - buf_valid<=0. No request is issued in the br_taken cycle; first redirected request goes out next cycle.
- Response accept: imem_rvalid and !out_drop and !br_taken gives a fetched instruction F={imem_rdata,out_pc}.
  - F goes to IF/ID if that register loads this cycle; otherwise it goes to the buffer (buf_valid<=1).
- Response with out_drop=1: discarded; state returns to IDLE.
- IF/ID update, priority order:
  1. flushD: instrD=NOP_INSN, validD=0, pcD unchanged.
  2. stallD: hold all.
  3. buf_valid: load the buffer, buf_valid<=0.
  4. Accepted F: load F, validD=1.
  5. Otherwise: bubble (NOP_INSN, validD=0).
- pc_plus4D is always registered as pcD+4 alongside pcD.
- Simultaneous events:
  - flushD with stallD: flush wins.
  - Buffer full and a new rvalid: cannot occur (no request while buf_valid).
  - rvalid and gnt in the same cycle: both handled.
- Latency:
  - Zero-wait memory (gnt same cycle, rvalid +1): first validD 2 cycles after reset release; 1 instruction/cycle sustained.
  - Redirect penalty: target instruction valid in D 3 cycles after the br_taken cycle.

Test Plan:
- Reset then zero-wait memory returning rdata=addr: validD rises in cycle 2; pcD = 0, 4, 8, … one per cycle; pc_plus4D = pcD+4.
- Memory with 3-cycle rvalid latency: imem_req low while WAIT; validD pulses once per 3 cycles; no address skipped or duplicated.
- stallF=stallD=1 for 4 cycles while a fetch of 0x10 is outstanding: response captured in the buffer; D held at 0x0C. After release, D=0x10 then 0x14, with no re-fetch of 0x10.
- br_taken with br_target=0x100 while fetch of 0x20 is outstanding (latency 2): 0x20 response dropped; next request addr=0x100; validD=0 until pcD=0x100.
- br_taken in the same cycle as rvalid for 0x08: 0x08 discarded; flushD gives NOP_INSN with validD=0; next fetch is the target.
- pcF=0xFFFF_FFFC granted: pcF wraps to 0x0000_0000. rst asserted mid-WAIT: all outputs return to reset values in the following cycle.
